// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: 640x480@60 defaults, counter type and range helper.
package vga_pkg;

  localparam int unsigned CNT_W       = 10;
  localparam int unsigned FRAME_CNT_W = 8;
  localparam int unsigned SYNC_STAGES = 2;

  // 640x480@60 timing, counted in 25 MHz pixel ticks and lines
  localparam int unsigned HPIXELS = 800;
  localparam int unsigned VLINES  = 525;
  localparam int unsigned HSYNC_W = 96;
  localparam int unsigned VSYNC_W = 2;
  localparam int unsigned HBP     = 144;
  localparam int unsigned HFP     = 784;
  localparam int unsigned VBP     = 35;
  localparam int unsigned VFP     = 515;

  typedef logic [CNT_W-1:0] cnt_t;

  // Half-open window test lo <= v < hi
  function automatic logic in_range(cnt_t v, cnt_t lo, cnt_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_clkdiv.sv
// Reset-release synchroniser and divide-by-two pixel tick generator.
module vga_clkdiv
  import vga_pkg::*;
(
  input  logic clk,
  input  logic clr_n,
  output logic pix_en,
  output logic run
);

  logic [SYNC_STAGES-1:0] sync;

  // Assert asynchronously, release through a two-flop chain
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Toggle divider: starts on the first stage so the tick lands on the second clk after release
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pix_en <= 1'b0;
    end else begin
      pix_en <= sync[0] & ~pix_en;
    end
  end

  // Counters may advance only once the full chain has released
  assign run = sync[SYNC_STAGES-1];

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with registered sync and blanking.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_timing
  import vga_pkg::cnt_t;
  import vga_pkg::in_range;
#(
  parameter int unsigned HPIXELS = vga_pkg::HPIXELS,
  parameter int unsigned VLINES  = vga_pkg::VLINES,
  parameter int unsigned HSYNC_W = vga_pkg::HSYNC_W,
  parameter int unsigned VSYNC_W = vga_pkg::VSYNC_W,
  parameter int unsigned HBP     = vga_pkg::HBP,
  parameter int unsigned HFP     = vga_pkg::HFP,
  parameter int unsigned VBP     = vga_pkg::VBP,
  parameter int unsigned VFP     = vga_pkg::VFP
) (
  input  logic       clk,
  input  logic       clr_n,
  output logic       pix_en,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync,
  output logic       vsync,
  output logic       vidon,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  logic run;
  logic tick_c;
  logic wrap_h_c;
  logic wrap_v_c;
  logic fs_c;
  cnt_t hc_nxt_c;
  cnt_t vc_nxt_c;

  vga_clkdiv u_clkdiv (
    .clk    (clk),
    .clr_n  (clr_n),
    .pix_en (pix_en),
    .run    (run)
  );

  // Next-state counters; >= compare keeps any stray value from escaping the range
  always_comb begin
    hc_nxt_c = hc;
    vc_nxt_c = vc;
    fs_c     = 1'b0;
    tick_c   = pix_en & run;
    wrap_h_c = hc >= cnt_t'(HPIXELS - 1);
    wrap_v_c = vc >= cnt_t'(VLINES - 1);
    if (tick_c) begin
      if (wrap_h_c) begin
        hc_nxt_c = '0;
        vc_nxt_c = wrap_v_c ? '0 : vc + cnt_t'(1);
        fs_c     = wrap_v_c;
      end else begin
        hc_nxt_c = hc + cnt_t'(1);
      end
    end
  end

  // Counters and decodes registered together so syncs align with hc/vc
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hc          <= '0;
      vc          <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      vidon       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hc          <= hc_nxt_c;
      vc          <= vc_nxt_c;
      hsync       <= hc_nxt_c >= cnt_t'(HSYNC_W);
      vsync       <= vc_nxt_c >= cnt_t'(VSYNC_W);
      vidon       <= in_range(hc_nxt_c, cnt_t'(HBP), cnt_t'(HFP)) &&
                     in_range(vc_nxt_c, cnt_t'(VBP), cnt_t'(VFP));
      frame_start <= fs_c;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Frames completed since reset, modulo 256
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      frame_cnt <= '0;
    end else if (fs_c) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule
